// File: rtl/btb_pkg.sv
// Shared types for the BTB update scheduler: the queued update record and the
// scheduler FSM state encoding.
package btb_pkg;
  localparam int Xlen         = 32;
  localparam int BtbIndexBits = 5;
  localparam int BtbEntries   = 1 << BtbIndexBits;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic [Xlen-1:0] target;
    logic            taken;
  } btb_update_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sched_state_e;
endpackage

// File: rtl/btb_update_fifo.sv
// Small registered FIFO with a synchronous clear; head entry is visible
// combinationally on rdata while not empty.
module btb_update_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  // Storage is data only; the pointers alone define which slots are live.
  always_ff @(posedge i_clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/btb_update_scheduler.sv
// Sequences EX branch-resolution updates and full-table invalidate sweeps into
// the BTB update port. Optional counters: define BTB_UPDATE_SCHED_STATS_EN.
module btb_update_scheduler
  import btb_pkg::*;
#(
  parameter int XLEN           = Xlen,
  parameter int BTB_INDEX_BITS = BtbIndexBits,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ex_valid,
  input  logic [XLEN-1:0]           i_ex_pc,
  input  logic [XLEN-1:0]           i_ex_target,
  input  logic                      i_ex_taken,
  input  logic                      i_flush_req,
  output logic                      o_flush_busy,
  output logic                      o_btb_update,
  output logic [XLEN-1:0]           o_btb_update_pc,
  output logic [XLEN-1:0]           o_btb_update_target,
  output logic                      o_btb_update_taken,
  output logic                      o_btb_inv,
  output logic [BTB_INDEX_BITS-1:0] o_btb_inv_index,
`ifdef BTB_UPDATE_SCHED_STATS_EN
  output logic [31:0]               o_stat_issued,
  output logic [31:0]               o_stat_dropped,
  output logic [15:0]               o_stat_flushes,
`endif
  output logic                      o_drop
);
  localparam logic [BTB_INDEX_BITS-1:0] IdxOne = {{(BTB_INDEX_BITS-1){1'b0}}, 1'b1};

  sched_state_e              state;
  sched_state_e              state_nxt;
  logic [BTB_INDEX_BITS-1:0] sweep_idx;
  logic                      sweep_last;
  btb_update_t               ex_entry;
  btb_update_t               head;
  btb_update_t               last;
  logic                      full;
  logic                      empty;
  logic                      issue;
  logic                      push;
  logic                      drop_d;
  logic                      drop_q;

  assign ex_entry   = '{pc: i_ex_pc, target: i_ex_target, taken: i_ex_taken};
  assign sweep_last = (sweep_idx == {BTB_INDEX_BITS{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_flush_req) state_nxt = SWEEP;
      SWEEP:   if (!i_flush_req && sweep_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A flush in the same cycle suppresses the issue: the head entry is stale.
  always_comb begin
    o_flush_busy    = (state == SWEEP);
    o_btb_inv       = (state == SWEEP);
    o_btb_inv_index = sweep_idx;
    issue           = (state == IDLE) && !empty && !i_flush_req;
  end

  // Counter wraps to zero naturally after the last index.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush_req) sweep_idx <= '0;
    else if (state == SWEEP)  sweep_idx <= sweep_idx + IdxOne;
    else                      sweep_idx <= '0;
  end

  assign push   = i_ex_valid && !i_flush_req && (!full || issue);
  assign drop_d = i_ex_valid && !i_flush_req && full && !issue;

  btb_update_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .T     (btb_update_t)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clear (i_flush_req),
    .push  (push),
    .wdata (ex_entry),
    .pop   (issue),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last   <= '0;
      drop_q <= 1'b0;
    end else begin
      if (issue) last <= head;
      drop_q <= drop_d;
    end
  end

  assign o_btb_update        = issue;
  assign o_btb_update_pc     = issue ? head.pc     : last.pc;
  assign o_btb_update_target = issue ? head.target : last.target;
  assign o_btb_update_taken  = issue ? head.taken  : last.taken;
  assign o_drop              = drop_q;

`ifdef BTB_UPDATE_SCHED_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_issued  <= '0;
      o_stat_dropped <= '0;
      o_stat_flushes <= '0;
    end else begin
      if (issue && (o_stat_issued != '1))        o_stat_issued  <= o_stat_issued + 32'd1;
      if (drop_q && (o_stat_dropped != '1))      o_stat_dropped <= o_stat_dropped + 32'd1;
      if (i_flush_req && (o_stat_flushes != '1)) o_stat_flushes <= o_stat_flushes + 16'd1;
    end
  end
`endif
endmodule

// File: doc/btb_update_scheduler.md
Name: btb_update_scheduler

Overview:
- Sequences all writes into the 32-entry BTB's single update port.
- Buffers branch-resolution updates from EX in a small FIFO.
- Runs a full-table invalidate sweep on flush requests (fence.i / context switch) through a per-index invalidate port.
- Arbitrates sweep vs. queued updates, with sweep priority; sits between the EX stage and the branch predictor.

Parameters:
- XLEN, 32, address/data width
- BTB_INDEX_BITS, 5, BTB index width; sweep length = 2**BTB_INDEX_BITS
- QUEUE_DEPTH, 4, update FIFO entries; power of two, >= 2

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_ex_valid  in  1  branch/jump resolved this cycle
- i_ex_pc  in  XLEN  PC of resolved branch
- i_ex_target  in  XLEN  resolved target
- i_ex_taken  in  1  resolved outcome
- i_flush_req  in  1  single-cycle pulse; invalidate whole BTB
- o_flush_busy  out  1  sweep in progress
- o_btb_update  out  1  BTB update strobe
- o_btb_update_pc  out  XLEN  update PC
- o_btb_update_target  out  XLEN  update target
- o_btb_update_taken  out  1  update outcome
- o_btb_inv  out  1  invalidate strobe (clears valid bit)
- o_btb_inv_index  out  BTB_INDEX_BITS  index to invalidate
- o_drop  out  1  pulse: EX update discarded, queue full

Behaviour:
- Reset: i_rst synchronous, active-high; clock i_clk.
  - On reset: FSM=IDLE, queue empty, sweep index 0.
  - All outputs 0.
  - Reset mid-sweep aborts the sweep immediately.
- FSM states IDLE and SWEEP:
  - IDLE -> SWEEP on i_flush_req.
  - SWEEP -> IDLE after index 2**BTB_INDEX_BITS-1 has been issued.
  - i_flush_req during SWEEP restarts the sweep at index 0.
- SWEEP behaviour:
  - One invalidate per cycle, indices ascending from 0.
  - o_btb_inv=1, o_btb_inv_index=sweep counter; counter wraps to 0 on exit.
  - o_flush_busy=1 exactly while in SWEEP (32 cycles for default parameters).
  - o_btb_update=0 throughout SWEEP.
- Flush discard rule:
  - Queue entries present when i_flush_req is sampled are discarded (they are stale).
  - An EX update in the same cycle as i_flush_req is also discarded.
  - EX updates arriving during SWEEP are enqueued and kept.
- Queue:
  - Registered FIFO; push on i_ex_valid (except the flush case above).
  - Issue: in IDLE with queue non-empty, drive the head entry on o_btb_update_* with o_btb_update=1 and pop the same cycle.
  - Latency: EX push in cycle N appears on o_btb_update in cycle N+1 at earliest.
  - No combinational path from i_ex_* to the outputs.
- Full / empty boundaries:
  - Full with a simultaneous pop (IDLE): push accepted.
  - Full without a pop (SWEEP): push dropped, o_drop=1 for one cycle, queue unchanged.
  - Empty: o_btb_update=0, and o_btb_update_* hold their last values.
- Pointers: log2(QUEUE_DEPTH) bits plus one wrap bit, for the full/empty distinction.
- Ordering: updates issue strictly in EX order; no coalescing.
- Mutual exclusion: o_btb_inv and o_btb_update are never asserted in the same cycle.

Optional Feature:
- Macro: BTB_UPDATE_SCHED_STATS_EN.
- When defined, adds outputs:
  - o_stat_issued (32b): counts o_btb_update cycles.
  - o_stat_dropped (32b): counts o_drop pulses.
  - o_stat_flushes (16b): counts sweeps started, restarts included.
  - All saturate at max and clear on reset.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package btb_pkg:
  - struct btb_update_t {pc, target, taken}
  - enum sched_state_e {IDLE, SWEEP}
  - localparam BtbEntries
- Sub-module btb_update_fifo: generic depth/struct FIFO with push, pop, full, empty, and flush-clear.
- The FSM, sweep counter and arbitration stay in the top module.

Test Plan:
- Reset, then EX push pc=0x100 target=0x200 taken=1 in cycle 5 -> cycle 6: o_btb_update=1 with the same pc/target/taken; cycle 7: o_btb_update=0.
- Three back-to-back pushes in IDLE -> three consecutive issues in order, 1-cycle lag, o_drop never set.
- Queue two entries, then i_flush_req with an EX update in the same cycle -> all three discarded; o_btb_inv indices 0..31 in consecutive cycles; o_flush_busy high for exactly 32 cycles.
- 6 EX updates during a sweep (depth 4) -> first 4 queued, o_drop pulses on the 5th and 6th; after the sweep, 4 updates issue on the 4 following cycles.
- i_flush_req at sweep index 17 -> o_btb_inv_index returns to 0; busy lasts 32 cycles from the restart.
- i_rst asserted at sweep index 10 with the queue non-empty -> next cycle all outputs 0, queue empty, state IDLE.
